// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the console UART.
//   rx_state_t   receiver FSM states
//   FRAME_BITS   data bits per character (8N1)
//   div_width()  width of a divider that counts 0..clks_per_bit-1
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int FRAME_BITS = 8;

  function automatic int div_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parameterized synchronous show-ahead FIFO.
//   clk, rst_n       clock, synchronous active-low reset (empties FIFO)
//   push, push_data  write request and data
//   pop              read request; ignored while empty
//   full, empty      registered status
//   head             oldest entry, presented without a pop
// Push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    count_n = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == CW'(DEPTH));
    end
  end

  // Head is a direct read of registered storage, so it only changes on a clock edge.
  assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver for the vc32 serial console.
//   clk, rst_n  clock, synchronous active-low reset
//   rx          asynchronous serial input, idle high
//   rd_valid    receive FIFO non-empty
//   rd_data     FIFO head byte
//   rd_ready    pops the head when rd_valid && rd_ready
//   frame_err   sticky: stop bit sampled low
//   overrun     sticky: byte completed while FIFO full and not popped
//   clr_err     clears both sticky flags (a coincident set wins)
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | half a bit in; confirm start bit is still low
// DATA  | sample 8 data bits LSB-first, one per bit period
// STOP  | sample stop bit; push byte or flag framing error
// BREAK | line held low after a bad stop bit; wait for high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int CW = div_width(CLKS_PER_BIT);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  rx_state_t             state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [BW-1:0]         bit_idx, bit_idx_n;
  logic [FRAME_BITS-1:0] sh, sh_n;
  logic                  rx_meta, rx_s;
  logic                  push;
  logic                  fe_set;
  logic                  fifo_full;
  logic                  fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      sh      <= sh_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = (cnt != '0) ? cnt - CW'(1) : cnt;
    bit_idx_n = bit_idx;
    sh_n      = sh;
    push      = 1'b0;
    fe_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_BIT;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            cnt_n     = FULL_BIT;
            bit_idx_n = '0;
            state_n   = DATA;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == '0) begin
          sh_n  = {rx_s, sh[FRAME_BITS-1:1]};
          cnt_n = FULL_BIT;
          if (bit_idx == LAST_BIT) state_n = STOP;
          else                     bit_idx_n = bit_idx + BW'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A full FIFO still takes the byte if the CPU pops in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (fe_set)       frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (push && fifo_full && !rd_ready) overrun <= 1'b1;
      else if (clr_err)                   overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (sh),
    .pop       (rd_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (rd_data)
  );

  assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized, scoreboard-checked bench for uart_rx
// (CLKS_PER_BIT=16, FIFO_DEPTH=4, 10 ns clock, 160 ns bit period).
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       frame_err;
  logic       overrun;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic       exp_fe = 1'b0;
  logic       exp_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 ns after the rising edge; the monitor samples on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: every pop the DUT performs must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data at %0t", rd_data, $time);
      end else begin
        chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Reference model: a frame with a high stop bit lands in the FIFO if there is
  // room or the CPU pops in the stop-sample cycle; otherwise it is an overrun.
  // A low stop bit is a framing error and stores nothing.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit pop_at_stop, input bit lat_chk);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop;
    if (stop) begin
      if (exp_q.size() < DEPTH || pop_at_stop) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end else begin
      exp_fe = 1'b1;
    end
    // Stop sample edge is 110 ns into the stop bit (2-flop sync + half-bit wait).
    repeat (10) tick();
    if (lat_chk) chk("rd_valid_before_stop_sample", 32'(rd_valid), 32'd0);
    if (pop_at_stop) rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    if (lat_chk) begin
      chk("rd_valid_after_stop_sample", 32'(rd_valid), 32'd1);
      chk("rd_data_after_stop_sample", 32'(rd_data), 32'(b));
    end
    repeat (CPB - 11) tick();
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    repeat (3 * DEPTH) tick();
    rd_ready = 1'b0;
    tick();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_rd_valid", 32'(rd_valid), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_fe  = 1'b0;
    exp_ovr = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    logic [7:0] b;

    // Reset with idle line
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (40) tick();
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Two bytes, no reads, then two single-cycle pops
    send_frame(8'h55, 1'b1, 0, 1);
    send_frame(8'hA3, 1'b1, 0, 0);
    repeat (CPB) tick();
    chk("head_first", 32'(rd_data), 32'h55);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("head_second", 32'(rd_data), 32'hA3);
    chk("valid_after_one_pop", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("valid_after_two_pops", 32'(rd_valid), 32'd0);

    // Short low glitch must be rejected by START
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    chk("glitch_rd_valid", 32'(rd_valid), 32'd0);
    chk("glitch_frame_err", 32'(frame_err), 32'd0);
    send_frame(8'h3C, 1'b1, 0, 1);
    repeat (CPB) tick();
    drain();

    // Framing error, then a held-low break
    send_frame(8'hF0, 1'b0, 0, 0);
    repeat (5 * CPB) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    chk("break_frame_err", 32'(frame_err), 32'(exp_fe));
    chk("break_rd_valid", 32'(rd_valid), 32'd0);
    chk("break_overrun", 32'(overrun), 32'(exp_ovr));
    pulse_clr();
    chk("clr_frame_err", 32'(frame_err), 32'd0);

    // Overrun: five bytes into a four-entry FIFO
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 0, 0);
    repeat (CPB) tick();
    chk("overrun_set", 32'(overrun), 32'(exp_ovr));
    chk("overrun_head", 32'(rd_data), 32'h01);
    drain();
    chk("overrun_sticky", 32'(overrun), 32'd1);
    pulse_clr();
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Same, but the CPU pops exactly in the 5th stop-sample cycle
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, (k == 5), 0);
    repeat (CPB) tick();
    chk("pop_at_full_overrun", 32'(overrun), 32'(exp_ovr));
    chk("pop_at_full_head", 32'(rd_data), 32'h02);
    drain();

    // Reset pulse during the last data bit of 0x81 abandons it
    b = 8'h81;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 7; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = b[7];
    repeat (CPB / 2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (CPB / 2 - 1) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    chk("midframe_reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("midframe_reset_frame_err", 32'(frame_err), 32'd0);
    send_frame(8'h7E, 1'b1, 0, 1);
    repeat (CPB) tick();
    drain();

    // Random bytes, random gaps, random reader
    done = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          b = 8'($urandom);
          send_frame(b, 1'b1, 0, 0);
          repeat ($urandom_range(0, 20)) tick();
        end
        repeat (2 * CPB) tick();
        done = 1;
      end
      begin
        while (!done) begin
          rd_ready = 1'($urandom_range(0, 1));
          tick();
        end
        rd_ready = 1'b0;
      end
    join
    drain();
    chk("final_frame_err", 32'(frame_err), 32'(exp_fe));
    chk("final_overrun", 32'(overrun), 32'(exp_ovr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Synthesizable 8N1 UART receiver for the vc32 CPU's serial console input; the counterpart of the CPU's TX path on uo_out[6].
- Samples an asynchronous rx pin, reconstructs bytes LSB-first and buffers them in a small show-ahead FIFO.
- The CPU reads the FIFO with a valid/ready handshake.
- Sticky framing-error and overrun flags are reported to the CPU's status register.

Parameters:
- CLKS_PER_BIT, 8000, clk cycles per bit. Matches the 80 us bit period at 100 MHz; must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx  in  1  asynchronous serial input; idle high
- rd_valid  out  1  FIFO non-empty
- rd_data  out  8  FIFO head byte; valid when rd_valid
- rd_ready  in  1  CPU pops the head when rd_valid && rd_ready
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: byte completed while FIFO full
- clr_err  in  1  clears frame_err and overrun

Behaviour:
- Reset:
  - Applied on the clk edge where rst_n==0.
  - Synchronizer flops are set to 1.
  - State goes to IDLE; bit counter and clock divider are cleared to 0.
  - FIFO is emptied: rd_valid=0, rd_data=0.
  - frame_err=0, overrun=0.
  - Reset mid-frame abandons the partial byte; nothing is pushed.
- Input synchronizer: two flops, rx -> rx_s, giving 2 cycles of latency. All decisions use rx_s only.
- Divider cnt is loaded on state entry and decrements each cycle. The sample point is cnt==0.
- IDLE: on rx_s==0, load cnt=CLKS_PER_BIT/2-1 and go to START.
- START: at cnt==0:
  - rx_s==0: load cnt=CLKS_PER_BIT-1, set bit=0, go to DATA.
  - rx_s==1: glitch; return to IDLE with no flag.
- DATA: at cnt==0, shift sh={rx_s, sh[7:1]} and reload cnt. After the 8th sample (bit==7), go to STOP with cnt=CLKS_PER_BIT-1.
- STOP: at cnt==0:
  - rx_s==1: push sh and go to IDLE. If the FIFO is full and not popped in the same cycle, drop the byte and set overrun.
  - rx_s==0: set frame_err, discard the byte, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line producing repeated frames.
- Latency: rd_valid rises in the cycle after the stop-bit sample edge.
- FIFO:
  - Show-ahead: rd_data always presents the head entry.
  - Count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: both take effect and count is unchanged. This applies when full (push is accepted, no overrun) and when empty (push only; pop is impossible since rd_valid=0).
  - rd_ready while !rd_valid is ignored.
  - rd_data is held stable while rd_valid && !rd_ready.
- Flags:
  - clr_err clears both flags.
  - If clr_err and a set event coincide, set wins (flag=1 next cycle).
- rd_valid, rd_data, frame_err and overrun are all registered outputs.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK}
  - localparam FRAME_BITS=8
  - function for the divider width, clog2(CLKS_PER_BIT)
- One sub-module, uart_rx_fifo:
  - Parameterized synchronous FIFO: push/push_data, pop, full, empty, head.
  - Reusable by the future TX buffer.
- Synchronizer and FSM stay in uart_rx.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4, bench drives rx with a 160 ns bit period at 10 ns clk):
- Reset with rx=1 -> rd_valid=0, frame_err=0, overrun=0. Line stays idle; nothing is ever pushed.
- Send 0x55 then 0xA3 with rd_ready=0 -> rd_valid=1 after the first stop sample with rd_data=0x55. Pulse rd_ready one cycle -> rd_data=0xA3 next cycle. Second pop -> rd_valid=0.
- 4-cycle low glitch on idle rx -> START rejects it, no push, no flag. A valid 0x3C sent immediately after is received correctly.
- Stop bit forced low on byte 0xF0 -> frame_err=1, FIFO unchanged. Hold rx low 5 bit times, then high -> no further frames. clr_err -> frame_err=0.
- Send 5 bytes 0x01..0x05 with rd_ready=0 -> FIFO holds 0x01..0x04 and overrun=1. Repeat with rd_ready asserted exactly in the 5th stop-sample cycle -> 0x05 accepted and overrun stays 0.
- Assert rst_n=0 for one cycle mid-DATA of byte 0x81 -> no push. The next byte, 0x7E, is received cleanly.
